// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: queue entry layout helpers.
// An entry packs {target, taken, pc}, with pc in the low bits.
package branch_resolve_unit_pkg;

    localparam int OFF_PC = 0;

    function automatic int entry_w(input int pcw);
        return 2 * pcw + 1;
    endfunction

    function automatic int off_taken(input int pcw);
        return pcw;
    endfunction

    function automatic int off_tgt(input int pcw);
        return pcw + 1;
    endfunction

endpackage

// File: rtl/bru_queue.sv
// Circular FIFO of in-flight predictions; head entry is visible combinationally.
// Clear wins over push/pop and empties the queue by snapping head to tail.
module bru_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign head_dat_o = mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + AW'(1);
            if (pop_i)  head_d = head_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only slots between head and tail are ever read as valid.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[tail_q] <= push_dat_i;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves in-order branches against recorded predictions; trains predictor,
// flags mispredicts one cycle after ex_valid and keeps hit/total counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pred_valid,
    input  logic [PCW-1:0] pred_pc,
    input  logic           pred_taken,
    input  logic [PCW-1:0] pred_target,
    output logic           queue_full,
    input  logic           ex_valid,
    input  logic           ex_taken,
    input  logic [PCW-1:0] ex_target,
    output logic [PCW-1:0] inst_last,
    output logic           taken_last,
    output logic           update_valid,
    output logic           mispredict,
    output logic [PCW-1:0] redirect_pc,
    output logic [31:0]    hit_count,
    output logic [31:0]    branch_count,
    output logic           underflow_err
);
    localparam int EW    = entry_w(PCW);
    localparam int OFF_T = off_taken(PCW);
    localparam int OFF_G = off_tgt(PCW);

    logic [EW-1:0]  push_ent, head_ent;
    logic           q_full, q_empty, q_push;
    logic [PCW-1:0] head_pc, head_tgt;
    logic           head_taken;
    logic           resolve, dir_ok, tgt_ok, correct, flush_now;
    logic [PCW-1:0] redirect_d;
    logic [31:0]    hit_d, branch_d;

    logic [PCW-1:0] inst_last_q, redirect_q;
    logic           taken_last_q, update_valid_q, mispredict_q, underflow_q;
    logic [31:0]    hit_q, branch_q;

    assign push_ent   = {pred_target, pred_taken, pred_pc};
    assign head_pc    = head_ent[OFF_PC +: PCW];
    assign head_taken = head_ent[OFF_T];
    assign head_tgt   = head_ent[OFF_G +: PCW];

    assign resolve   = ex_valid && !q_empty;
    assign dir_ok    = (head_taken == ex_taken);
    assign tgt_ok    = !ex_taken || (head_tgt == ex_target);
    assign correct   = dir_ok && tgt_ok;
    assign flush_now = resolve && !correct;
    // A prediction arriving alongside a flush is on the wrong path.
    assign q_push    = pred_valid && !q_full && !flush_now;

    assign redirect_d = ex_taken ? ex_target : head_pc + PCW'(4);
    assign branch_d   = branch_q + 32'(resolve);
    assign hit_d      = hit_q + 32'(resolve && correct);

    bru_queue #(.DEPTH(DEPTH), .W(EW)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (q_push),
        .push_dat_i (push_ent),
        .pop_i      (resolve),
        .clear_i    (flush_now),
        .head_dat_o (head_ent),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_last_q    <= '0;
            taken_last_q   <= 1'b0;
            update_valid_q <= 1'b0;
            mispredict_q   <= 1'b0;
            redirect_q     <= '0;
            hit_q          <= '0;
            branch_q       <= '0;
            underflow_q    <= 1'b0;
        end else begin
            update_valid_q <= resolve;
            mispredict_q   <= flush_now;
            hit_q          <= hit_d;
            branch_q       <= branch_d;
            if (resolve) begin
                inst_last_q  <= head_pc;
                taken_last_q <= ex_taken;
                redirect_q   <= redirect_d;
            end
            if (ex_valid && q_empty) underflow_q <= 1'b1;
        end
    end

    assign queue_full    = q_full;
    assign inst_last     = inst_last_q;
    assign taken_last    = taken_last_q;
    assign update_valid  = update_valid_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_q;
    assign hit_count     = hit_q;
    assign branch_count  = branch_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid, pred_taken, ex_valid, ex_taken;
    logic [31:0] pred_pc, pred_target, ex_target;
    logic        queue_full, taken_last, update_valid, mispredict, underflow_err;
    logic [31:0] inst_last, redirect_pc, hit_count, branch_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .PCW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .queue_full    (queue_full),
        .ex_valid      (ex_valid),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .inst_last     (inst_last),
        .taken_last    (taken_last),
        .update_valid  (update_valid),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .hit_count     (hit_count),
        .branch_count  (branch_count),
        .underflow_err (underflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
        ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        idle();
        pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tgt;
        tick();
        idle();
    endtask

    task automatic res(input logic tk, input logic [31:0] tgt);
        idle();
        ex_valid = 1'b1; ex_taken = tk; ex_target = tgt;
        tick();
        idle();
    endtask

    logic [31:0] pcs [4];

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        chk("rst_full", 32'(queue_full), 0);
        chk("rst_upd", 32'(update_valid), 0);
        chk("rst_mis", 32'(mispredict), 0);
        chk("rst_inst", inst_last, 0);
        chk("rst_taken", 32'(taken_last), 0);
        chk("rst_redir", redirect_pc, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_br", branch_count, 0);
        chk("rst_uf", 32'(underflow_err), 0);

        // Correct taken prediction
        enq(32'h100, 1'b1, 32'h200);
        res(1'b1, 32'h200);
        chk("t1_upd", 32'(update_valid), 1);
        chk("t1_inst", inst_last, 32'h100);
        chk("t1_taken", 32'(taken_last), 1);
        chk("t1_mis", 32'(mispredict), 0);
        chk("t1_hit", hit_count, 1);
        chk("t1_br", branch_count, 1);
        tick();
        chk("t1_pulse", 32'(update_valid), 0);

        // Predicted not-taken, actually taken
        enq(32'h104, 1'b0, 32'h0);
        res(1'b1, 32'h300);
        chk("t2_mis", 32'(mispredict), 1);
        chk("t2_redir", redirect_pc, 32'h300);
        chk("t2_taken", 32'(taken_last), 1);
        chk("t2_hit", hit_count, 1);
        chk("t2_br", branch_count, 2);
        tick();
        chk("t2_pulse", 32'(mispredict), 0);

        // Predicted taken, actually not taken: fall through to pc+4
        enq(32'h108, 1'b1, 32'h400);
        res(1'b0, 32'h0);
        chk("t3_mis", 32'(mispredict), 1);
        chk("t3_redir", redirect_pc, 32'h10C);
        chk("t3_inst", inst_last, 32'h108);
        chk("t3_taken", 32'(taken_last), 0);

        // Fill, drop a fifth prediction, drain back-to-back
        pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h208; pcs[3] = 32'h20C;
        for (int i = 0; i < 4; i++) enq(pcs[i], 1'b0, 32'h0);
        chk("t4_full", 32'(queue_full), 1);
        enq(32'h210, 1'b0, 32'h0);
        chk("t4_full_hold", 32'(queue_full), 1);
        for (int i = 0; i < 4; i++) begin
            res(1'b0, 32'h0);
            chk($sformatf("t4_inst%0d", i), inst_last, pcs[i]);
            chk($sformatf("t4_upd%0d", i), 32'(update_valid), 1);
            chk($sformatf("t4_mis%0d", i), 32'(mispredict), 0);
        end
        chk("t4_notfull", 32'(queue_full), 0);
        chk("t4_hit", hit_count, 5);
        chk("t4_br", branch_count, 7);

        // Wrong target flushes younger entries and the same-cycle prediction
        enq(32'h300, 1'b1, 32'h500);
        enq(32'h304, 1'b0, 32'h0);
        enq(32'h308, 1'b0, 32'h0);
        ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h504;
        pred_valid = 1'b1; pred_pc = 32'h30C; pred_taken = 1'b0; pred_target = 32'h0;
        tick();
        idle();
        chk("t5_mis", 32'(mispredict), 1);
        chk("t5_redir", redirect_pc, 32'h504);
        chk("t5_full", 32'(queue_full), 0);
        chk("t5_hit", hit_count, 5);
        chk("t5_br", branch_count, 8);
        chk("t5_uf0", 32'(underflow_err), 0);
        res(1'b0, 32'h0);
        chk("t5_uf", 32'(underflow_err), 1);
        chk("t5_noupd", 32'(update_valid), 0);
        chk("t5_br_hold", branch_count, 8);
        tick();
        chk("t5_uf_sticky", 32'(underflow_err), 1);

        // Reset while entries are queued and a resolve is in flight
        enq(32'h400, 1'b0, 32'h0);
        enq(32'h404, 1'b0, 32'h0);
        enq(32'h408, 1'b0, 32'h0);
        ex_valid = 1'b1; ex_taken = 1'b0; ex_target = 32'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("t6_upd", 32'(update_valid), 0);
        chk("t6_inst", inst_last, 0);
        chk("t6_hit", hit_count, 0);
        chk("t6_br", branch_count, 0);
        chk("t6_uf", 32'(underflow_err), 0);
        chk("t6_full", 32'(queue_full), 0);
        res(1'b0, 32'h0);
        chk("t6_empty_uf", 32'(underflow_err), 1);
        chk("t6_empty_upd", 32'(update_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
